trigger_network_sync: RTL and testbench
=======================================

Name: trigger_network_sync

Overview:
- Network-level scheduler above N actor triggers.
- Aggregates per-trigger sleep and sync status into a global idle-detection and synchronisation round; broadcasts the sync phase signals back to every trigger.
- Exposes an ap_start/ap_done/ap_idle/ap_ready block-level handshake to the host kernel wrapper.
- Declares the network finished only when every actor has waited through a full sync round without executing.

Parameters:
- NUM_TRIGGERS, 4, number of actor triggers supervised (1..32).
- SLEEP_CYCLES, 16, consecutive all-sleep cycles required before starting a sync round (1..65535).
- ROUND_W, 16, width of the round counters.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous, active-high reset
- ap_start  in  1  host start request, level
- ap_done  out  1  one-cycle pulse, network finished
- ap_idle  out  1  controller in IDLE
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- sleep  in  NUM_TRIGGERS  trigger i in SLEEP state
- sync_wait  in  NUM_TRIGGERS  trigger i in SYNC_WAIT
- sync_exec  in  NUM_TRIGGERS  trigger i in SYNC_EXEC
- all_sleep  out  1  broadcast: every trigger asleep (registered)
- all_sync  out  1  broadcast: sync round in progress
- all_sync_wait  out  1  one-cycle pulse: round ended, no trigger executed
- all_sync_exec  out  1  one-cycle pulse: round ended, at least one trigger executed
- sync_rounds  out  ROUND_W  sync rounds completed since start (stats)
- run_cycles  out  32  cycles spent outside IDLE since start (stats)

Behaviour:
- All outputs are registered. On reset: ap_idle=1; every other output is 0; counters are 0; state is IDLE.
- ap_rst is sampled only on the ap_clk edge and overrides any state, including mid-round; no done pulse is emitted.
- States: IDLE, RUN, SYNC, DONE.
- IDLE:
  - ap_idle=1.
  - ap_start=1 moves to RUN next cycle and clears the sleep counter, sync_rounds and run_cycles.
- RUN:
  - sleep_cnt increments while &sleep; it resets to 0 on any cycle where &sleep=0.
  - all_sleep is the registered &sleep.
  - When sleep_cnt reaches SLEEP_CYCLES-1 with &sleep=1, go to SYNC; all_sync rises the following cycle.
  - With SLEEP_CYCLES=1, SYNC is entered one cycle after the first all-sleep cycle.
- SYNC:
  - all_sync=1 throughout.
  - Trigger i has settled when sync_wait[i] or sync_exec[i] is set.
  - When every trigger has settled:
    - If |sync_exec: pulse all_sync_exec, drop all_sync, increment sync_rounds, return to RUN with sleep_cnt=0.
    - Otherwise: pulse all_sync_wait, drop all_sync, increment sync_rounds, go to DONE.
  - If one trigger asserts both sync_wait and sync_exec, it is treated as exec.
  - sleep is ignored while in SYNC.
- DONE:
  - ap_done=ap_ready=1 for exactly one cycle, then IDLE.
  - If ap_start is still high in IDLE, a new run begins the next cycle (back-to-back runs allowed).
- Counters:
  - sync_rounds saturates at all-ones and does not wrap.
  - run_cycles increments every cycle in RUN, SYNC or DONE, and saturates at all-ones.
- Latency: the minimum start-to-done path with immediately sleeping, idle triggers is 1 + SLEEP_CYCLES + 1 + 1 cycles.

Optional Feature:
- Macro: TRIGGER_NETWORK_SYNC_STATS_EN.
- Defined: sync_rounds and run_cycles are live as specified above.
- Undefined: the counter registers are not synthesised; sync_rounds and run_cycles are tied to 0. The ports remain, and control behaviour is unchanged.

Decomposition:
- Shared TriggerTypes package gains:
  - netsync_state_t, a 2-bit enum {NS_IDLE, NS_RUN, NS_SYNC, NS_DONE}.
  - Constant NETSYNC_MAX_TRIGGERS = 32.
- One sub-module: trigger_sleep_debounce, the saturating consecutive-cycle counter with clear, threshold parameter and hit output, used for sleep_cnt.

Test Plan:
- Reset/idle: hold ap_rst 3 cycles with ap_start=1 -> ap_idle=1 and all other outputs 0 throughout; RUN is entered 1 cycle after ap_rst falls.
- Direct finish (N=4, SLEEP_CYCLES=4): sleep=4'hF from start; in SYNC drive sync_wait=4'hF -> one all_sync_wait pulse, then ap_done/ap_ready pulse 1 cycle later, sync_rounds=1, then ap_idle=1.
- Exec round: first round drive sync_exec=4'b0010, sync_wait=4'b1101 -> all_sync_exec pulse and return to RUN; second round all wait -> done with sync_rounds=2.
- Sleep glitch: sleep=4'hF for 3 cycles, 4'h7 for 1 cycle, then 4'hF -> SYNC entered only after 4 further consecutive all-sleep cycles.
- Partial settle: sync_wait=4'b0111 held for 10 cycles -> all_sync stays 1 and no pulses; setting bit 3 -> all_sync_wait pulse the next cycle.
- Mid-round reset: assert ap_rst while in SYNC -> next cycle ap_idle=1, all_sync=0, no ap_done, counters 0.

Source files
------------

// File: rtl/trigger_network_sync_pkg.sv
// Shared types and limits for the trigger network synchronisation controller.
// Optional statistics counters are enabled with TRIGGER_NETWORK_SYNC_STATS_EN.
package trigger_network_sync_pkg;

  localparam int NETSYNC_MAX_TRIGGERS = 32;

  typedef enum logic [1:0] {
    NS_IDLE = 2'd0,
    NS_RUN  = 2'd1,
    NS_SYNC = 2'd2,
    NS_DONE = 2'd3
  } netsync_state_t;

endpackage

// File: rtl/trigger_sleep_debounce.sv
// Counts consecutive cycles of an active input and flags the cycle on which
// the run reaches THRESHOLD; clear or a gap restarts the count from zero.
module trigger_sleep_debounce #(
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);

  logic [CNT_W-1:0] cnt;

  assign hit = active && (cnt == LAST);

  // Count saturates at LAST so a long sleep run never wraps back into a false hit.
  always_ff @(posedge clk) begin
    if (rst || clear || !active) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/trigger_network_sync.sv
// Network-level idle detection and sync-round scheduler above N actor triggers.
// Define TRIGGER_NETWORK_SYNC_STATS_EN to make sync_rounds/run_cycles live.
module trigger_network_sync
  import trigger_network_sync_pkg::*;
#(
  parameter int NUM_TRIGGERS = 4,
  parameter int SLEEP_CYCLES = 16,
  parameter int ROUND_W      = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic [NUM_TRIGGERS-1:0] sleep,
  input  logic [NUM_TRIGGERS-1:0] sync_wait,
  input  logic [NUM_TRIGGERS-1:0] sync_exec,
  output logic                    all_sleep,
  output logic                    all_sync,
  output logic                    all_sync_wait,
  output logic                    all_sync_exec,
  output logic [ROUND_W-1:0]      sync_rounds,
  output logic [31:0]             run_cycles
);

  netsync_state_t state;
  netsync_state_t state_nx;
  logic           all_asleep;
  logic           settled;
  logic           any_exec;
  logic           sleep_hit;

  assign all_asleep = &sleep;
  // A trigger flagging both wait and exec counts as exec via any_exec.
  assign settled    = &(sync_wait | sync_exec);
  assign any_exec   = |sync_exec;

  trigger_sleep_debounce #(
    .THRESHOLD (SLEEP_CYCLES),
    .CNT_W     (16)
  ) u_sleep_debounce (
    .clk    (ap_clk),
    .rst    (ap_rst),
    .clear  (state != NS_RUN),
    .active (all_asleep),
    .hit    (sleep_hit)
  );

  always_comb begin
    state_nx = state;
    case (state)
      NS_IDLE: state_nx = ap_start ? NS_RUN : NS_IDLE;
      NS_RUN:  state_nx = sleep_hit ? NS_SYNC : NS_RUN;
      NS_SYNC: begin
        if (!settled) begin
          state_nx = NS_SYNC;
        end else if (any_exec) begin
          state_nx = NS_RUN;
        end else begin
          state_nx = NS_DONE;
        end
      end
      NS_DONE: state_nx = NS_IDLE;
      default: state_nx = NS_IDLE;
    endcase
  end

  // Broadcasts and handshake are registered alongside the state they describe.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= NS_IDLE;
      ap_idle       <= 1'b1;
      ap_done       <= 1'b0;
      ap_ready      <= 1'b0;
      all_sleep     <= 1'b0;
      all_sync      <= 1'b0;
      all_sync_wait <= 1'b0;
      all_sync_exec <= 1'b0;
    end else begin
      state         <= state_nx;
      ap_idle       <= (state_nx == NS_IDLE);
      ap_done       <= (state == NS_DONE);
      ap_ready      <= (state == NS_DONE);
      all_sleep     <= (state == NS_RUN) && all_asleep;
      all_sync      <= (state_nx == NS_SYNC);
      all_sync_wait <= (state == NS_SYNC) && settled && !any_exec;
      all_sync_exec <= (state == NS_SYNC) && settled && any_exec;
    end
  end

`ifdef TRIGGER_NETWORK_SYNC_STATS_EN
  logic round_end;

  assign round_end = (state == NS_SYNC) && settled;

  // Stats clear on a fresh start and otherwise hold, so they stay readable after done.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sync_rounds <= '0;
      run_cycles  <= '0;
    end else if (state == NS_IDLE) begin
      if (ap_start) begin
        sync_rounds <= '0;
        run_cycles  <= '0;
      end else begin
        sync_rounds <= sync_rounds;
        run_cycles  <= run_cycles;
      end
    end else begin
      if (!(&run_cycles)) begin
        run_cycles <= run_cycles + 32'd1;
      end else begin
        run_cycles <= run_cycles;
      end
      if (round_end && !(&sync_rounds)) begin
        sync_rounds <= sync_rounds + ROUND_W'(1);
      end else begin
        sync_rounds <= sync_rounds;
      end
    end
  end
`else
  assign sync_rounds = '0;
  assign run_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_trigger_network_sync.sv
// Self-checking bench for trigger_network_sync: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_trigger_network_sync;

  localparam int N  = 4;
  localparam int SC = 4;
  localparam int RW = 16;
`ifdef TRIGGER_NETWORK_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  slp = '0;
  logic [N-1:0]  w = '0;
  logic [N-1:0]  e = '0;
  logic          ap_done, ap_idle, ap_ready;
  logic          all_sleep, all_sync, all_sync_wait, all_sync_exec;
  logic [RW-1:0] sync_rounds;
  logic [31:0]   run_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: run/round/finishing flags and a count of consecutive all-sleep cycles.
  bit       m_running = 1'b0;
  bit       m_round   = 1'b0;
  bit       m_finish  = 1'b0;
  int       m_streak  = 0;
  longint   m_rounds  = 0;
  longint   m_cycles  = 0;
  logic [6:0] m_flags = 7'b1000000;

  trigger_network_sync #(.NUM_TRIGGERS(N), .SLEEP_CYCLES(SC), .ROUND_W(RW)) dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .sleep(slp), .sync_wait(w), .sync_exec(e),
    .all_sleep(all_sleep), .all_sync(all_sync),
    .all_sync_wait(all_sync_wait), .all_sync_exec(all_sync_exec),
    .sync_rounds(sync_rounds), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [3:0]  slp;
    logic [3:0]  w;
    logic [3:0]  e;
    logic [6:0]  flags;   // {idle, done, ready, all_sleep, all_sync, sync_wait, sync_exec}
    logic [15:0] rounds;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({ap_idle, ap_done, ap_ready, all_sleep, all_sync, all_sync_wait, all_sync_exec,
                sync_rounds, run_cycles});
  endfunction

  function automatic logic [63:0] mk_vec(input logic [6:0] f, input longint r, input longint c);
    logic [15:0] rr;
    logic [31:0] cc;
    rr = STATS ? 16'(r) : 16'd0;
    cc = STATS ? 32'(c) : 32'd0;
    return 64'({f, rr, cc});
  endfunction

  task automatic bump_cycles();
    if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
  endtask

  task automatic model_edge();
    bit sw = 1'b0, se = 1'b0, dn = 1'b0, sl = 1'b0;
    if (rst) begin
      m_running = 1'b0; m_round = 1'b0; m_finish = 1'b0;
      m_streak = 0; m_rounds = 0; m_cycles = 0;
      m_flags = 7'b1000000;
      return;
    end
    if (m_finish) begin
      m_finish = 1'b0; m_running = 1'b0; dn = 1'b1; bump_cycles();
    end else if (m_round) begin
      bump_cycles();
      if (&(w | e)) begin
        if (m_rounds < 65535) m_rounds++;
        m_round = 1'b0; m_streak = 0;
        if (|e) se = 1'b1;
        else begin sw = 1'b1; m_finish = 1'b1; end
      end
    end else if (m_running) begin
      bump_cycles();
      sl = &slp;
      m_streak = (&slp) ? m_streak + 1 : 0;
      if (m_streak >= SC) m_round = 1'b1;
    end else if (start) begin
      m_running = 1'b1; m_streak = 0; m_rounds = 0; m_cycles = 0;
    end
    m_flags = {!m_running, dn, dn, sl, m_round, sw, se};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check("cycle", dut_vec(), mk_vec(m_flags, m_rounds, m_cycles));
  endtask

  task automatic wait_sync();
    int k = 0;
    while (!all_sync && k < 20) begin
      tick();
      k++;
    end
    check("wait_sync_bound", 64'(all_sync), 64'd1);
  endtask

  initial begin
    int cnt;
    bit ok;
    tbl[0] = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 7'b1000000, 16'd0, 32'd0};
    tbl[1] = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 7'b0000000, 16'd0, 32'd0};
    tbl[2] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 7'b0001000, 16'd0, 32'd1};
    tbl[3] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 7'b0001000, 16'd0, 32'd2};
    tbl[4] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 7'b0001000, 16'd0, 32'd3};
    tbl[5] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 7'b0001100, 16'd0, 32'd4};
    tbl[6] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h0, 7'b0000010, 16'd1, 32'd5};
    tbl[7] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 7'b1110000, 16'd1, 32'd6};
    tbl[8] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 7'b1000000, 16'd1, 32'd6};

    // Direct finish as a vector table: start-to-done is 1+SC+1+1 edges.
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; slp = tbl[i].slp; w = tbl[i].w; e = tbl[i].e;
      tick();
      check($sformatf("vec%0d", i), dut_vec(), mk_vec(tbl[i].flags, longint'(tbl[i].rounds),
                                                     longint'(tbl[i].cyc)));
    end

    // Reset held with start high: idle only; RUN one cycle after release.
    rst = 1'b1; start = 1'b1; slp = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_idle", dut_vec(), mk_vec(7'b1000000, 0, 0));
    end
    rst = 1'b0;
    tick();
    check("run_entry", 64'(ap_idle), 64'd0);
    start = 1'b0;

    // Sleep glitch restarts the consecutive count.
    slp = 4'hF;
    repeat (3) tick();
    slp = 4'h7;
    tick();
    slp = 4'hF;
    cnt = 0;
    while (!all_sync && cnt < 20) begin
      tick();
      cnt++;
    end
    check("glitch_len", 64'(cnt), 64'(SC));

    // Partial settle holds the round open.
    w = 4'b0111; e = 4'h0;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (!all_sync || all_sync_wait || all_sync_exec || ap_done) ok = 1'b0;
    end
    check("partial_hold", 64'(ok), 64'd1);
    w = 4'hF;
    tick();
    check("partial_release", 64'({all_sync_wait, all_sync}), 64'(2'b10));
    w = 4'h0;
    tick();
    check("done_pulse", 64'({ap_done, ap_ready, ap_idle}), 64'(3'b111));
    tick();
    check("done_single", 64'({ap_done, ap_ready}), 64'd0);

    // Exec round returns to RUN; second all-wait round finishes.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sync();
    w = 4'b1101; e = 4'b0010;
    tick();
    check("exec_pulse", 64'({all_sync_exec, all_sync_wait, all_sync, ap_idle}), 64'(4'b1000));
    w = 4'h0; e = 4'h0;
    wait_sync();
    w = 4'hF;
    tick();
    check("exec_round2_wait", 64'(all_sync_wait), 64'd1);
    w = 4'h0;
    tick();
    check("exec_done", 64'(ap_done), 64'd1);
    check("exec_rounds", 64'(sync_rounds), STATS ? 64'd2 : 64'd0);

    // Mid-round reset: back to idle without any done pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sync();
    rst = 1'b1;
    tick();
    check("midrst", dut_vec(), mk_vec(7'b1000000, 0, 0));
    rst = 1'b0;
    tick();
    check("midrst_nodone", 64'({ap_done, ap_idle}), 64'(2'b01));

    // Randomized traffic, model compared every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) != 0);
      slp   = ($urandom_range(0, 7) != 0) ? 4'hF : 4'($urandom);
      e     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      w     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
